uart_wb_host: RTL
=================

UART_WB_HOST -- requirements
Module: uart_wb_host

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 64, clk cycles between status polls while idle.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, max clk cycles a bus cycle waits for wb_ack.
REQ-003 SHALL have ports: clk in 1, single clock; all logic on rising edge.
REQ-004 SHALL have ports: reset in 1, synchronous, active-high.
REQ-005 SHALL have ports: wb_addr out 2, UART register address.
REQ-006 SHALL have ports: wb_data_out out 8, write data to the UART's wb_data_in.
REQ-007 SHALL have ports: wb_data_in in 8, read data from the UART's wb_data_out.
REQ-008 SHALL have ports: wb_we out 1, 1 = read, 0 = write (UART convention).
REQ-009 SHALL have ports: wb_stb out 1, bus cycle request; wb_ack in 1, UART completion.
REQ-010 SHALL have ports: tx_valid in 1, tx_data in 8, tx_ready out 1, user byte to send.
REQ-011 SHALL have ports: rx_valid out 1, rx_data out 8, received byte, one-cycle pulse.
REQ-012 SHALL have ports: bus_err out 1, one-cycle pulse on ack timeout.

Function
REQ-013 SHALL use the UART map: addr 0 TX data (write), addr 1 RX data (read), addr 2 status (read; bit0 rx_ready, bit1 tx_busy).
REQ-014 SHALL hold a one-byte TX holding register; tx_ready = holding empty and no echo pending; load on tx_valid and tx_ready.
REQ-015 SHALL implement FSM states IDLE, STAT, RXRD, TXWR.
REQ-016 SHALL, in IDLE, count poll cycles; go to STAT when holding or echo is pending, or when the counter reaches POLL_INTERVAL-1; clear the counter on leaving.
REQ-017 SHALL, in STAT, assert wb_stb, wb_addr=2, wb_we=1; on wb_ack latch wb_data_in and deassert wb_stb in the next cycle.
REQ-018 SHALL, after STAT: go to RXRD if rx_ready=1; else to TXWR if a byte is pending and tx_busy=0; else to IDLE.
REQ-019 SHALL, in RXRD, assert wb_stb, addr 1, wb_we=1; on ack, drive rx_data=wb_data_in and rx_valid=1 for exactly one cycle, then go to IDLE.
REQ-020 SHALL, in TXWR, assert wb_stb, addr 0, wb_we=0, wb_data_out=pending byte (echo before holding register); on ack, clear that source and go to IDLE.
REQ-021 SHALL hold wb_stb, wb_addr, wb_we and wb_data_out stable from assertion until ack or timeout.
REQ-022 SHALL, if a bus cycle sees no wb_ack within ACK_TIMEOUT cycles, drop wb_stb, pulse bus_err once, and return to IDLE with all pending bytes kept.
REQ-023 SHALL ignore wb_ack while wb_stb=0.
REQ-024 SHALL give RX priority over TX: a TX write issues only after a status read reports rx_ready=0.
REQ-025 SHALL NOT change tx_ready in the same cycle that a TXWR ack frees the holding register; tx_ready rises the following cycle.

Reset
REQ-026 SHALL, on reset, force state IDLE, poll counter 0, holding and echo empty, wb_stb=0, wb_we=1, wb_addr=0, wb_data_out=0, rx_valid=0, rx_data=0, bus_err=0, tx_ready=0 during the reset cycle.
REQ-027 SHALL abandon any bus cycle in progress on reset, dropping wb_stb in the first reset cycle.

Configuration
REQ-028 SHALL compile echo when UART_HOST_ECHO_EN is defined: each RXRD ack also loads the echo register with the received byte, and tx_ready=0 while echo is pending.
REQ-029 SHALL, without UART_HOST_ECHO_EN, omit the echo register; received bytes go only to rx_data/rx_valid.

Verification
REQ-030 Reset, tx_valid=1 with tx_data=0x42, UART status 0x00 -> STAT read, then write addr 0 with data 0x42, we=0; tx_ready rises one cycle after the ack.
REQ-031 Idle, UART status 0x01 and RX data 0x47 -> status read within POLL_INTERVAL cycles, then read addr 1; rx_valid pulses one cycle with rx_data=0x47.
REQ-032 UART_HOST_ECHO_EN defined, RX 0x47 then status 0x00 -> next bus write is addr 0, data 0x47; tx_ready stays 0 until that ack.
REQ-033 wb_ack held low -> wb_stb drops after ACK_TIMEOUT=16 cycles, bus_err pulses once, pending byte 0x42 is retried on the next poll.
REQ-034 Status 0x03 with a byte pending -> RX read first; TX write only after a status read returns bit0=0 and bit1=0.
REQ-035 reset asserted while wb_stb=1 in TXWR -> wb_stb=0 in the next cycle, holding register empty, no rx_valid and no bus_err pulse.

Source files
------------

// File: rtl/uart_wb_host.sv
// Wishbone host for a UART: polls the status register, reads RX bytes, writes TX bytes.
// Define UART_HOST_ECHO_EN to echo every received byte back out on TX.
`timescale 1ns/1ps
module uart_wb_host #(
   parameter int POLL_INTERVAL = 64,
   parameter int ACK_TIMEOUT   = 16
) (
   input  logic       clk,
   input  logic       reset,
   output logic [1:0] wb_addr,
   output logic [7:0] wb_data_out,
   input  logic [7:0] wb_data_in,
   output logic       wb_we,
   output logic       wb_stb,
   input  logic       wb_ack,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       bus_err
);
   localparam int CNT_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
   localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, STAT, RXRD, TXWR} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] poll_cnt_q;
   logic [TMO_W-1:0] tmo_q;
   logic             stb_q, we_q, rx_valid_q, bus_err_q, tx_ready_q;
   logic [1:0]       addr_q;
   logic [7:0]       dout_q, rx_data_q, hold_data_q;
   logic             hold_full_q, hold_full_d, src_echo_q;
   logic             echo_pend, echo_next;
   logic [7:0]       echo_byte;
   logic             pending, tmo_hit, tx_load, tx_done, rx_done, tx_ready_d;

   assign pending = hold_full_q | echo_pend;
   assign tmo_hit = stb_q && !wb_ack && (tmo_q == TMO_W'(ACK_TIMEOUT - 1));
   assign tx_load = tx_valid && tx_ready_q;
   assign tx_done = (state_q == TXWR) && stb_q && wb_ack;
   assign rx_done = (state_q == RXRD) && stb_q && wb_ack;

   always_comb begin
      hold_full_d = hold_full_q;
      if (tx_done && !src_echo_q) hold_full_d = 1'b0;
      if (tx_load) hold_full_d = 1'b1;
   end

   // tx_ready is registered, so a freed holding register shows up one cycle after the ack
   assign tx_ready_d = !hold_full_d && !echo_next;

`ifdef UART_HOST_ECHO_EN
   logic       echo_full_q, echo_full_d;
   logic [7:0] echo_data_q;

   always_comb begin
      echo_full_d = echo_full_q;
      if (tx_done && src_echo_q) echo_full_d = 1'b0;
      if (rx_done) echo_full_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) echo_full_q <= 1'b0;
      else       echo_full_q <= echo_full_d;
      if (rx_done) echo_data_q <= wb_data_in;
   end

   assign echo_pend = echo_full_q;
   assign echo_next = echo_full_d;
   assign echo_byte = echo_data_q;
`else
   assign echo_pend = 1'b0;
   assign echo_next = 1'b0;
   assign echo_byte = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         poll_cnt_q  <= '0;
         tmo_q       <= '0;
         stb_q       <= 1'b0;
         we_q        <= 1'b1;
         addr_q      <= 2'd0;
         dout_q      <= 8'h00;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h00;
         bus_err_q   <= 1'b0;
         hold_full_q <= 1'b0;
         tx_ready_q  <= 1'b0;
         src_echo_q  <= 1'b0;
      end else begin
         rx_valid_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         hold_full_q <= hold_full_d;
         tx_ready_q  <= tx_ready_d;
         if (tx_load) hold_data_q <= tx_data;
         if (stb_q && !wb_ack) tmo_q <= tmo_q + TMO_W'(1);
         case (state_q)
            IDLE: begin
               if (pending || poll_cnt_q == CNT_W'(POLL_INTERVAL - 1)) begin
                  poll_cnt_q <= '0;
                  state_q    <= STAT;
                  stb_q      <= 1'b1;
                  addr_q     <= 2'd2;
                  we_q       <= 1'b1;
                  tmo_q      <= '0;
               end else begin
                  poll_cnt_q <= poll_cnt_q + CNT_W'(1);
               end
            end
            STAT: begin
               if (stb_q && wb_ack) begin
                  stb_q <= 1'b0;
                  // RX always wins; TX only when nothing is waiting and the UART is free
                  if (wb_data_in[0])                 state_q <= RXRD;
                  else if (pending && !wb_data_in[1]) state_q <= TXWR;
                  else                               state_q <= IDLE;
               end else if (tmo_hit) begin
                  stb_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            RXRD: begin
               if (!stb_q) begin
                  stb_q  <= 1'b1;
                  addr_q <= 2'd1;
                  we_q   <= 1'b1;
                  tmo_q  <= '0;
               end else if (rx_done) begin
                  stb_q      <= 1'b0;
                  rx_valid_q <= 1'b1;
                  rx_data_q  <= wb_data_in;
                  state_q    <= IDLE;
               end else if (tmo_hit) begin
                  stb_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            TXWR: begin
               if (!stb_q) begin
                  stb_q      <= 1'b1;
                  addr_q     <= 2'd0;
                  we_q       <= 1'b0;
                  dout_q     <= echo_pend ? echo_byte : hold_data_q;
                  src_echo_q <= echo_pend;
                  tmo_q      <= '0;
               end else if (tx_done) begin
                  stb_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (tmo_hit) begin
                  stb_q     <= 1'b0;
                  bus_err_q <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign wb_stb      = stb_q;
   assign wb_addr     = addr_q;
   assign wb_we       = we_q;
   assign wb_data_out = dout_q;
   assign tx_ready    = tx_ready_q;
   assign rx_valid    = rx_valid_q;
   assign rx_data     = rx_data_q;
   assign bus_err     = bus_err_q;
endmodule
